// File: rtl/delay_line_var.sv
// Variable-tap, clock-enabled delay line carrying a data word and its valid flag.
// Delay is sel+1 enabled cycles (clamped to DEPTH), with synchronous flush and an in-flight valid count.
module delay_line_var #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8,
    parameter int SEL_W = 3,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CLK_en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Taps beyond the last stage read the last stage.
    function automatic int tap_index(input logic [SEL_W-1:0] s);
        if (int'(s) >= DEPTH) begin
            return DEPTH - 1;
        end
        return int'(s);
    endfunction

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            data_d[k] = data_q[k];
        end
        vld_d = vld_q;
        cnt_d = cnt_q;
        if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_d[k] = '0;
            end
            vld_d = '0;
            cnt_d = '0;
        end else if (CLK_en) begin
            data_d[0] = in;
            for (int k = 1; k < DEPTH; k++) begin
                data_d[k] = data_q[k-1];
            end
            vld_d = {vld_q[DEPTH-2:0], in_valid};
            // Word entering and word leaving cancel; cnt stays within 0..DEPTH.
            cnt_d = cnt_q + CNT_W'(in_valid) - CNT_W'(vld_q[DEPTH-1]);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= data_d[k];
            end
            vld_q <= vld_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        out       = '0;
        out_valid = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (tap_index(sel) == k) begin
                out       = data_q[k];
                out_valid = vld_q[k];
            end
        end
    end

    assign count = cnt_q;

endmodule

// File: tb/tb_delay_line_var.sv
// Self-checking bench for delay_line_var: directed vector table, corner-case sequences and a
// randomized run compared against a queue-based model of the delay line.
module tb_delay_line_var;

    localparam int W = 20;
    localparam int D = 8;
    localparam int SW = 4;
    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          CLK_en = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in = '0;
    logic [SW-1:0] sel = '0;
    logic [W-1:0]  out;
    logic          out_valid;
    logic [CW-1:0] count;

    int checks = 0;
    int passes = 0;

    delay_line_var #(.WIDTH(W), .DEPTH(D), .SEL_W(SW), .CNT_W(CW)) dut (
        .CLK(CLK), .RESET(RESET), .CLK_en(CLK_en), .flush(flush),
        .in_valid(in_valid), .in(in), .sel(sel),
        .out(out), .out_valid(out_valid), .count(count)
    );

    always #5 CLK = ~CLK;

    // Model: queue of {valid, data}, index 0 is the newest word.
    logic [W:0] mq[$];

    task automatic model_clear();
        mq.delete();
        for (int i = 0; i < D; i++) mq.push_back('0);
    endtask

    task automatic model_edge();
        if (flush) model_clear();
        else if (CLK_en) begin
            mq.push_front({in_valid, in});
            void'(mq.pop_back());
        end
    endtask

    function automatic logic [W:0] model_tap(input int s);
        return mq[(s > D - 1) ? D - 1 : s];
    endfunction

    function automatic int model_count();
        int n = 0;
        foreach (mq[i]) n += int'(mq[i][W]);
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else passes++;
    endtask

    task automatic chk_model(input string nm);
        logic [W:0] t;
        t = model_tap(int'(sel));
        chk({nm, ".out"}, 32'(out), 32'(t[W-1:0]));
        chk({nm, ".vld"}, 32'(out_valid), 32'(t[W]));
        chk({nm, ".cnt"}, 32'(count), 32'(model_count()));
    endtask

    task automatic tick(input string nm);
        @(posedge CLK);
        model_edge();
        #1;
        chk_model(nm);
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        flush = 1'b0; CLK_en = 1'b0; in_valid = 1'b0; in = '0; sel = '0;
        model_clear();
        @(posedge CLK); #1;
        RESET = 1'b1;
    endtask

    task automatic drive(input logic f, input logic e, input logic v, input logic [W-1:0] d,
                         input logic [SW-1:0] s);
        flush = f; CLK_en = e; in_valid = v; in = d; sel = s;
    endtask

    typedef struct {
        logic          f, e, v;
        logic [W-1:0]  d;
        logic [SW-1:0] s;
        logic [W-1:0]  xo;
        logic          xv;
        logic [CW-1:0] xc;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [W-1:0] a, b;
        vecs[0] = '{1, 1, 1, 20'hAAAAA, 0, 20'hAAAAA, 1, 1};
        vecs[0].f = 0;
        vecs[1] = '{0, 1, 0, 20'hBBBBB, 0, 20'hBBBBB, 0, 1};
        vecs[2] = '{0, 0, 1, 20'hCCCCC, 0, 20'hBBBBB, 0, 1};
        vecs[3] = '{0, 1, 1, 20'hDDDDD, 1, 20'hBBBBB, 0, 2};
        vecs[4] = '{0, 1, 1, 20'hEEEEE, 2, 20'hBBBBB, 0, 3};
        vecs[5] = '{0, 0, 0, 20'h00000, 3, 20'hAAAAA, 1, 3};
        vecs[6] = '{1, 1, 1, 20'hFFFFF, 0, 20'h00000, 0, 0};
        vecs[7] = '{0, 1, 1, 20'h12345, 15, 20'h00000, 0, 1};
        vecs[8] = '{0, 1, 0, 20'h00007, 0, 20'h00007, 0, 1};

        do_reset();
        chk("reset.out", 32'(out), 0);
        chk("reset.vld", 32'(out_valid), 0);
        chk("reset.cnt", 32'(count), 0);

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].f, vecs[i].e, vecs[i].v, vecs[i].d, vecs[i].s);
            tick($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.out", i), 32'(out), 32'(vecs[i].xo));
            chk($sformatf("vec%0d.vld", i), 32'(out_valid), 32'(vecs[i].xv));
            chk($sformatf("vec%0d.cnt", i), 32'(count), 32'(vecs[i].xc));
        end

        // Fixed latency with sel = 3
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            drive(0, 1, 1, W'(k), 3);
            tick("lat");
            chk("lat.cnt_ramp", 32'(count), (k < D) ? k : D);
            if (k >= 4) begin
                chk("lat.out", 32'(out), k - 3);
                chk("lat.vld", 32'(out_valid), 1);
            end
        end

        // Async reset with full pipeline, then disabled hold
        #2 RESET = 1'b0;
        model_clear();
        #1;
        chk("areset.out", 32'(out), 0);
        chk("areset.vld", 32'(out_valid), 0);
        chk("areset.cnt", 32'(count), 0);
        @(posedge CLK); #1;
        RESET = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 1, 20'hABCDE, 3);
            tick("hold");
            chk("hold.out", 32'(out), 0);
            chk("hold.cnt", 32'(count), 0);
        end

        // Stall accounting with sel = 2
        do_reset();
        drive(0, 1, 1, 20'h11, 2); tick("stall.a");
        drive(0, 1, 1, 20'h22, 2); tick("stall.b");
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, 20'h99, 2);
            tick("stall.hold");
            chk("stall.not_yet", 32'(out), 0);
        end
        drive(0, 1, 0, 20'h0, 2); tick("stall.c");
        chk("stall.arrive", 32'(out), 32'h11);
        chk("stall.arrive_vld", 32'(out_valid), 1);

        // Flush priority over enable
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            drive(0, 1, 1, W'(k * 16), 0);
            tick("fl.fill");
        end
        chk("fl.cnt5", 32'(count), 5);
        drive(1, 1, 1, 20'h55, 0); tick("fl.flush");
        chk("fl.cnt0", 32'(count), 0);
        flush = 1'b0; CLK_en = 1'b0;
        for (int s = 0; s < 16; s++) begin
            sel = SW'(s); #1;
            chk("fl.tap", 32'(out), 0);
        end
        for (int k = 0; k < 10; k++) begin
            drive(0, 1, 0, 20'h0, SW'(k));
            tick("fl.drain");
            chk("fl.no55", 32'(out == 20'h55), 0);
        end

        // Clamp and combinational tap switch
        do_reset();
        for (int k = 0; k < 12; k++) begin
            drive(0, 1, 1'($urandom_range(0, 1)), W'($urandom), 7);
            tick("clamp");
            a = out;
            sel = 15; #1;
            b = out;
            chk("clamp.same", 32'(b), 32'(a));
        end
        sel = 5; #1;
        chk_model("sw5");
        sel = 1; #1;
        chk_model("sw1");

        // Count balance with alternating valid
        do_reset();
        for (int k = 0; k < 20; k++) begin
            drive(0, 1, 1'(k % 2 == 0), W'(k), 0);
            tick("bal");
            chk("bal.range", 32'(count <= D), 1);
        end
        chk("bal.settle", 32'(count), 4);

        // Randomized run against the model
        do_reset();
        for (int k = 0; k < 300; k++) begin
            drive(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), W'($urandom), SW'($urandom_range(0, 15)));
            tick("rand");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/delay_line_var.md
# delay_line_var

Parametrised, clock-enabled, variable-tap pipeline delay line for pixel and sideband alignment in the demosaic datapath. It is the generalised successor of the fixed single-stage 20-bit enable register. It delays a WIDTH-bit word plus its valid flag by a runtime-selectable 1..DEPTH enabled cycles, supports a synchronous flush, and keeps a running count of valid samples in flight. Instances sit between the line buffers and the interpolation kernels to equalise path latencies.

## Interface
- WIDTH, 20, data word width in bits (≥1)
- DEPTH, 8, number of stages (≥2)
- SEL_W, 3, width of `sel`; must satisfy 2^SEL_W ≥ DEPTH
- CNT_W, 4, width of `count`; must satisfy 2^CNT_W > DEPTH

Ports:
- CLK, input, 1, clock; all state changes on rising edge
- RESET, input, 1, asynchronous active-low reset
- CLK_en, input, 1, stage enable; when low, all state holds
- flush, input, 1, synchronous clear of the pipeline; takes priority over CLK_en
- in_valid, input, 1, valid flag travelling with `in`
- in, input, WIDTH, data word
- sel, input, SEL_W, tap select; delay = sel+1 enabled cycles
- out, output, WIDTH, data at the selected tap (combinational mux of stage registers)
- out_valid, output, 1, valid flag at the selected tap
- count, output, CNT_W, number of set valid bits across all DEPTH stages (registered)

## Operation
- State: data stages d[0..DEPTH-1], valid stages v[0..DEPTH-1], counter cnt.
- RESET low (async): all d = 0, all v = 0, cnt = 0. Therefore out = 0, out_valid = 0, count = 0.
- Per rising edge, the rules are applied in priority order:
  1. flush = 1 (regardless of CLK_en): all d = 0, all v = 0, cnt = 0.
  2. CLK_en = 0: hold everything. Input is ignored and dropped.
  3. CLK_en = 1:
     - d[0] <= in; v[0] <= in_valid
     - d[k] <= d[k-1] and v[k] <= v[k-1] for k = 1..DEPTH-1
     - cnt <= cnt + in_valid − v[DEPTH-1]. This may not over- or underflow, since 0 ≤ cnt ≤ DEPTH always holds.
- Tap: eff = min(sel, DEPTH-1). out = d[eff]; out_valid = v[eff]. A sel value ≥ DEPTH clamps to the last stage.
- Data bits are shifted whether or not the valid bit is set; invalid words are carried, not zeroed.
- Changing sel mid-stream takes effect combinationally on the same cycle. There is no realignment and no gap-filling; the bench must not expect any.
- Invariant: count equals popcount(v) at every cycle boundary.

## Timing
- Latency: a word accepted on enabled edge N appears at out after the (sel+1)-th enabled edge, counting edge N as the first. Disabled cycles do not count.
- With sel = 0, the word is visible on out after the accepting edge. This matches the fixed one-stage enable register exactly.
- out and out_valid are combinational from registers and sel. There is no path from in to out.
- count updates on the same edge as the shift and reflects the post-shift contents.
- Simultaneous flush and CLK_en: flush wins. The word on `in` that cycle is discarded.
- Simultaneous in_valid = 1 entering and v[DEPTH-1] = 1 leaving: count is unchanged.
- Reset mid-stream: outputs clear immediately (asynchronously), without waiting for a clock edge.
- Release of RESET is assumed synchronised externally. The first edge after release behaves normally.

## Test plan
- Reset/hold: assert RESET mid-run with the pipeline full. Required: out = 0, out_valid = 0, count = 0 before the next edge. Then hold CLK_en = 0 for 5 cycles with in = 0xABCDE, in_valid = 1. Required: outputs and count are unchanged.
- Fixed latency: sel = 3, CLK_en = 1, stream in = 1,2,3,… with in_valid = 1. Required: out = 1 and out_valid = 1 on the cycle after the 4th edge. count ramps 1..8 and then stays at 8.
- Stall accounting: sel = 2. Feed 0x11 and 0x22, then CLK_en = 0 for 3 cycles, then resume. Required: 0x11 reaches out after exactly 3 enabled edges; the stall cycles do not count.
- Flush priority: pipeline holding 5 valid words, then flush = 1 and CLK_en = 1 with in_valid = 1, in = 0x55. Required: next cycle count = 0, all taps read 0, and 0x55 is never output.
- Clamp and tap switch: DEPTH = 8, sel = 7 vs sel = 15 on identical streams. Required: identical out. Switching sel from 5 to 1 mid-stream gives an immediate value change with no valid repair.
- Count balance: alternating in_valid pattern 1,0,1,0… Required: count settles at 4 with DEPTH = 8 and never exceeds 8 or goes negative. Checked against popcount of the v-stage model every cycle.
